// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, with a Start/Busy/Done handshake.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOperation,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    state_t      state_r, state_s;
    logic [4:0]  cnt_r;
    logic [31:0] hiw_r, low_r, opnd_r;
    logic        is_div_r, neg_lo_r, neg_hi_r;
    logic [31:0] hi_r, lo_r;
    logic        busy_r, done_r;

    logic        accept_s, signed_op_s, div_op_s, div0_s;
    logic [32:0] mul_sum_s;
    logic        div_ge_s;
    logic [31:0] div_diff_s;
    logic [31:0] hiw_next_s, low_next_s;
    logic [63:0] prod_s;
    logic [31:0] fix_hi_s, fix_lo_s;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    assign accept_s    = Start && (state_r == ST_IDLE) && !MDOperation[2];
    assign signed_op_s = !MDOperation[0];
    assign div_op_s    = MDOperation[1];
    assign div0_s      = div_op_s && (B == 32'd0);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_RUN;
                else          state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (cnt_r == 5'd0) state_s = ST_FIX;
                else               state_s = ST_RUN;
            end
            ST_FIX:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // One iteration of the multiply or divide engine
    always_comb begin
        mul_sum_s  = {1'b0, hiw_r} + (low_r[0] ? {1'b0, opnd_r} : 33'd0);
        div_ge_s   = ({hiw_r, low_r[31]} >= {1'b0, opnd_r});
        div_diff_s = {hiw_r[30:0], low_r[31]} - opnd_r;
        hiw_next_s = hiw_r;
        low_next_s = low_r;
        if (is_div_r) begin
            if (div_ge_s) begin
                hiw_next_s = div_diff_s;
                low_next_s = {low_r[30:0], 1'b1};
            end else begin
                hiw_next_s = {hiw_r[30:0], low_r[31]};
                low_next_s = {low_r[30:0], 1'b0};
            end
        end else begin
            hiw_next_s = mul_sum_s[32:1];
            low_next_s = {mul_sum_s[0], low_r[31:1]};
        end
    end

    // Sign correction of the unsigned magnitude result
    always_comb begin
        prod_s   = {hiw_r, low_r};
        fix_hi_s = hiw_r;
        fix_lo_s = low_r;
        if (is_div_r) begin
            if (neg_lo_r) fix_lo_s = 32'd0 - low_r;
            else          fix_lo_s = low_r;
            if (neg_hi_r) fix_hi_s = 32'd0 - hiw_r;
            else          fix_hi_s = hiw_r;
        end else begin
            if (neg_lo_r) prod_s = 64'd0 - {hiw_r, low_r};
            else          prod_s = {hiw_r, low_r};
            fix_hi_s = prod_s[63:32];
            fix_lo_s = prod_s[31:0];
        end
    end

    // Engine datapath: operand latch on accept, iterate during RUN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r    <= 5'd0;
            hiw_r    <= 32'd0;
            low_r    <= 32'd0;
            opnd_r   <= 32'd0;
            is_div_r <= 1'b0;
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
        end else if (accept_s) begin
            // A zero divisor keeps the raw dividend so the engine yields LO=all-ones, HI=A
            cnt_r    <= 5'd31;
            hiw_r    <= 32'd0;
            low_r    <= (signed_op_s && !div0_s) ? abs32(A) : A;
            opnd_r   <= (signed_op_s && !div0_s) ? abs32(B) : B;
            is_div_r <= div_op_s;
            neg_lo_r <= signed_op_s && !div0_s && (A[31] ^ B[31]);
            neg_hi_r <= signed_op_s && !div0_s && A[31];
        end else if (state_r == ST_RUN) begin
            cnt_r <= (cnt_r == 5'd0) ? 5'd0 : (cnt_r - 5'd1);
            hiw_r <= hiw_next_s;
            low_r <= low_next_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Architectural HI/LO registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (state_r == ST_FIX) begin
            hi_r <= fix_hi_s;
            lo_r <= fix_lo_s;
        end else if (Start && (state_r == ST_IDLE) && (MDOperation == OP_MTHI)) begin
            hi_r <= A;
        end else if (Start && (state_r == ST_IDLE) && (MDOperation == OP_MTLO)) begin
            lo_r <= A;
        end else begin
            hi_r <= hi_r;
        end
    end

    // Registered handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            done_r <= (state_r == ST_FIX);
        end
    end

    assign Busy = busy_r;
    assign Done = done_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written corner
// sequences, and random operations checked against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOperation;
    logic [31:0] A, B;
    logic        Busy, Done;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    mult_div_unit dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOperation(MDOperation),
        .A(A), .B(B), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        string       name;
    } vec_t;

    vec_t vecs[12];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    // Reference model straight from the arithmetic definition of each operation
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        longint unsigned p;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'b000: begin p = longint'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            3'b001: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            3'b010: begin
                if (b == 32'd0) begin hi = a; lo = 32'hFFFFFFFF; end
                else begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
            end
            default: begin
                if (b == 32'd0) begin hi = a; lo = 32'hFFFFFFFF; end
                else begin hi = a % b; lo = a / b; end
            end
        endcase
    endtask

    // Called at a negedge: presents a request for one edge, then scrambles the inputs
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; MDOperation = op; A = a; B = b;
        @(negedge clk);
        Start = 1'b0; MDOperation = 3'($urandom); A = $urandom; B = $urandom;
    endtask

    // Waits out Busy (bounded), checking HI/LO hold, latency, Done and results
    task automatic finish_op(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        bit bad;
        n = 0;
        bad = 1'b0;
        while (Busy && n < 40) begin
            if (HI !== hi_m || LO !== lo_m || Done !== 1'b0) bad = 1'b1;
            n++;
            @(negedge clk);
        end
        chk32({name, "_latency"}, 32'(n), 32'd33);
        chk1({name, "_hold"}, bad, 1'b0);
        chk1({name, "_done"}, Done, 1'b1);
        chk32({name, "_hi"}, HI, exp_hi);
        chk32({name, "_lo"}, LO, exp_lo);
        hi_m = exp_hi;
        lo_m = exp_lo;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b, ehi, elo;
        int done_cnt, busy_cnt;

        vecs[0]  = '{3'b001, 32'd7,          32'd6,          32'd0,          32'd42,         "multu_7x6"};
        vecs[1]  = '{3'b000, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,          32'd1,          "mult_m1xm1"};
        vecs[2]  = '{3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   32'h00000001,   "multu_max"};
        vecs[3]  = '{3'b010, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD,   "div_m7_2"};
        vecs[4]  = '{3'b011, 32'd100,        32'd7,          32'd2,          32'd14,         "divu_100_7"};
        vecs[5]  = '{3'b010, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   "div_ovf"};
        vecs[6]  = '{3'b011, 32'h00001234,   32'd0,          32'h00001234,   32'hFFFFFFFF,   "divu_by0"};
        vecs[7]  = '{3'b010, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   32'hFFFFFFFF,   "div_by0"};
        vecs[8]  = '{3'b000, 32'h80000000,   32'h80000000,   32'h40000000,   32'd0,          "mult_minsq"};
        vecs[9]  = '{3'b000, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF,   32'hFFFFFFF1,   "mult_m3x5"};
        vecs[10] = '{3'b010, 32'd7,          32'hFFFFFFFE,   32'd1,          32'hFFFFFFFD,   "div_7_m2"};
        vecs[11] = '{3'b011, 32'hFFFFFFFF,   32'd1,          32'd0,          32'hFFFFFFFF,   "divu_max_1"};

        reset = 1'b0; Start = 1'b0; MDOperation = 3'd0; A = 32'd0; B = 32'd0;
        repeat (3) @(negedge clk);
        chk1("rst_busy", Busy, 1'b0);
        chk1("rst_done", Done, 1'b0);
        chk32("rst_hi", HI, 32'd0);
        chk32("rst_lo", LO, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed vectors, issued back-to-back on the first edge Busy is low
        foreach (vecs[i]) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            chk1({vecs[i].name, "_busy_on"}, Busy, 1'b1);
            chk1({vecs[i].name, "_done_low"}, Done, 1'b0);
            finish_op(vecs[i].name, vecs[i].hi, vecs[i].lo);
        end
        @(negedge clk);
        chk1("done_clear", Done, 1'b0);
        chk1("busy_idle", Busy, 1'b0);

        // MTHI then MTLO on consecutive edges
        Start = 1'b1; MDOperation = 3'b100; A = 32'hDEADBEEF;
        @(negedge clk);
        chk32("mthi_hi", HI, 32'hDEADBEEF);
        chk1("mthi_busy", Busy, 1'b0);
        MDOperation = 3'b101; A = 32'h12345678;
        @(negedge clk);
        Start = 1'b0;
        chk32("mtlo_lo", LO, 32'h12345678);
        chk32("mtlo_hi", HI, 32'hDEADBEEF);
        chk1("mtlo_busy", Busy, 1'b0);
        chk1("mtlo_done", Done, 1'b0);
        hi_m = 32'hDEADBEEF;
        lo_m = 32'h12345678;

        // Reserved codes do nothing
        Start = 1'b1; MDOperation = 3'b110; A = 32'h0BADF00D;
        @(negedge clk);
        MDOperation = 3'b111;
        @(negedge clk);
        Start = 1'b0;
        chk32("rsv_hi", HI, hi_m);
        chk32("rsv_lo", LO, lo_m);
        chk1("rsv_busy", Busy, 1'b0);

        // Start held for 10 cycles yields a single operation
        Start = 1'b1; MDOperation = 3'b001; A = 32'd3; B = 32'd5;
        done_cnt = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (c == 9) Start = 1'b0;
            if (c >= 0 && c < 9) begin A = $urandom; B = $urandom; end
            if (Done) done_cnt++;
        end
        chk32("held_start_dones", 32'(done_cnt), 32'd1);
        chk32("held_start_lo", LO, 32'd15);
        chk32("held_start_hi", HI, 32'd0);
        hi_m = 32'd0;
        lo_m = 32'd15;

        // Reset in the middle of a multiply
        start_op(3'b000, 32'd1000, 32'd1000);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        #1;
        chk1("midrst_busy", Busy, 1'b0);
        chk1("midrst_done", Done, 1'b0);
        chk32("midrst_hi", HI, 32'd0);
        chk32("midrst_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        hi_m = 32'd0;
        lo_m = 32'd0;
        done_cnt = 0;
        busy_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done) done_cnt++;
            if (Busy) busy_cnt++;
        end
        chk32("postrst_dones", 32'(done_cnt), 32'd0);
        chk32("postrst_busy", 32'(busy_cnt), 32'd0);
        start_op(3'b000, 32'd1000, 32'd1000);
        finish_op("postrst_mult", 32'd0, 32'd1000000);
        @(negedge clk);

        // Random operations against the reference model
        for (int k = 0; k < 24; k++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            model(op, a, b, ehi, elo);
            start_op(op, a, b);
            finish_op("rand", ehi, elo);
            @(negedge clk);
            chk1("rand_done_clear", Done, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
